fifo_rd_drain: RTL and testbench
================================

// Module: fifo_rd_drain
// PURPOSE
//   Read-side controller for the async FIFO, in the FIFO read clock domain.
//   - Issues FIFO read enables while the FIFO is non-empty.
//   - Absorbs the FIFO's 1-cycle registered read latency.
//   - Presents the data downstream as a valid/ready stream through a 3-entry output buffer.
//   - Counts words delivered.
//   It is the consumer counterpart of the FIFO write-side stimulus/producer.
// PARAMETERS
//   DATASIZE  8  data width, equal to the FIFO data width
//   CNTSIZE   16 width of delivered-word counter
// PORTS
//   i_rd_clk        in   1         read clock (single clock domain)
//   i_rd_rst        in   1         reset, synchronous, active-high
//   i_enable        in   1         1 = allow new FIFO reads; 0 = stop issuing reads
//   i_fifo_empty    in   1         FIFO empty flag
//   o_fifo_rd_en    out  1         FIFO read enable
//   i_fifo_rd_data  in   DATASIZE  FIFO read data, valid the cycle after o_fifo_rd_en=1
//   o_m_valid       out  1         downstream data valid
//   i_m_ready       in   1         downstream ready
//   o_m_data        out  DATASIZE  downstream data (buffer head)
//   o_word_cnt      out  CNTSIZE   words accepted downstream, modulo 2^CNTSIZE
// BEHAVIOUR
//   Reset (i_rd_rst=1 at posedge): occ=0, inflight=0, buffer pointers=0, o_word_cnt=0.
//   - While i_rd_rst=1, o_fifo_rd_en=0.
//   - After reset: o_m_valid=0, o_m_data=0.
//   - Buffered and in-flight words are discarded; no partial word survives.
//   State:
//   - occ: 0..3 words held in buffer.
//   - inflight: 1 bit, registered copy of o_fifo_rd_en.
//   o_fifo_rd_en = !i_rd_rst & i_enable & !i_fifo_empty & (occ + inflight < 3)
//   - Combinational. No path from i_m_ready, so no ready->rd_en timing loop.
//   Capture: if inflight=1 at posedge, i_fifo_rd_data is written at the buffer tail.
//   Pop: o_m_valid & i_m_ready at posedge; head advances, o_word_cnt++.
//   occ_next = occ + inflight - pop. Capture and pop in the same cycle are both performed.
//   - occ never exceeds 3 by construction; implement an assertion for it.
//   o_m_valid = (occ != 0).
//   - o_m_data is stable while o_m_valid=1 and i_m_ready=0.
//   - o_m_data holds its last value when occ=0.
//   Latency: o_fifo_rd_en=1 in cycle N -> o_m_valid=1 in cycle N+2 (buffer previously empty).
//   Throughput: i_m_ready=1 and FIFO non-empty -> 1 word/cycle sustained.
//   Boundaries:
//   - i_fifo_empty rising mid-stream: reads stop in the same cycle; the in-flight word is still captured.
//   - i_enable deasserted: reads stop immediately; in-flight and buffered words still drain downstream.
//   - i_m_ready=0 for a long time: rd_en stops once occ+inflight=3. No FIFO word is lost or duplicated.
//   - o_word_cnt wraps from 2^CNTSIZE-1 to 0 without a flag.
//   - Buffer pointers wrap mod 3.
//   - Order: output order equals FIFO read order, always.
// TESTING
//   1. Reset: i_rd_rst=1 for 2 cycles, FIFO non-empty -> o_fifo_rd_en=0, o_m_valid=0, o_word_cnt=0.
//   2. Single word: FIFO holds 0xA5, ready=1 -> rd_en pulses 1 cycle at N; o_m_valid=1, o_m_data=0xA5 at N+2; o_word_cnt=1.
//   3. Stream: 16 random words, ready=1 -> 16 consecutive rd_en cycles; outputs match a scoreboard in order; o_word_cnt=16.
//   4. Backpressure: ready=0 for 10 cycles mid-stream -> exactly 3 words buffered, rd_en=0, o_m_data held.
//      Ready=1 then -> no loss or duplication.
//   5. Empty and enable: FIFO empties after word 5, refills later; i_enable toggled 0 for 4 cycles -> no reads while empty or disabled, data intact.
//   6. Reset mid-op: assert i_rd_rst with occ=2 and inflight=1 -> next cycle o_m_valid=0, o_word_cnt=0.
//      Post-reset reads resume cleanly. With CNTSIZE=4, 17 pops -> o_word_cnt=1.

Source files
------------

// File: rtl/fifo_rd_drain_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_drain_if
//   Bundles the FIFO read port and the downstream valid/ready stream of the
//   read-side drain controller.
//   master : the drain controller (drives rd_en and the downstream stream)
//   slave  : the FIFO plus downstream consumer seen from the other side
//   Signals:
//     i_fifo_empty    FIFO empty flag
//     o_fifo_rd_en    FIFO read enable
//     i_fifo_rd_data  FIFO read data, valid the cycle after o_fifo_rd_en
//     o_m_valid       downstream data valid
//     i_m_ready       downstream ready
//     o_m_data        downstream data (output buffer head)
//     o_word_cnt      words accepted downstream, wrapping
// -----------------------------------------------------------------------------
interface fifo_rd_drain_if #(
  parameter int DATASIZE = 8,
  parameter int CNTSIZE  = 16
);
  logic                i_fifo_empty;
  logic                o_fifo_rd_en;
  logic [DATASIZE-1:0] i_fifo_rd_data;
  logic                o_m_valid;
  logic                i_m_ready;
  logic [DATASIZE-1:0] o_m_data;
  logic [CNTSIZE-1:0]  o_word_cnt;

  modport master (
    input  i_fifo_empty, i_fifo_rd_data, i_m_ready,
    output o_fifo_rd_en, o_m_valid, o_m_data, o_word_cnt
  );

  modport slave (
    output i_fifo_empty, i_fifo_rd_data, i_m_ready,
    input  o_fifo_rd_en, o_m_valid, o_m_data, o_word_cnt
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// -----------------------------------------------------------------------------
// fifo_rd_drain
//   Read-side controller for the async FIFO, in the FIFO read clock domain.
//   Issues read enables while the FIFO is non-empty and there is room for the
//   word, absorbs the FIFO's one-cycle registered read latency, presents the
//   words downstream as a valid/ready stream through a 3-entry buffer and
//   counts the words accepted downstream.
//   Ports:
//     i_rd_clk   read clock
//     i_rd_rst   synchronous active-high reset
//     i_enable   1 = allow new FIFO reads, 0 = stop issuing reads
//     bus        fifo_rd_drain_if.master (FIFO read port + downstream stream)
// -----------------------------------------------------------------------------
module fifo_rd_drain #(
  parameter int DATASIZE = 8,
  parameter int CNTSIZE  = 16
) (
  input  logic            i_rd_clk,
  input  logic            i_rd_rst,
  input  logic            i_enable,
  fifo_rd_drain_if.master bus
);

  logic [1:0]          occ_q, occ_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          head_q, head_d;
  logic [1:0]          tail_q, tail_d;
  logic [DATASIZE-1:0] mem_q [0:2];
  logic [DATASIZE-1:0] data_q, data_d;
  logic [CNTSIZE-1:0]  cnt_q, cnt_d;

  logic                rd_en_s;
  logic                valid_s;
  logic                pop_s;
  logic [2:0]          occ_sum_s;

  // Buffer pointers walk 0,1,2,0,...
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read enable counts the in-flight word as already occupying a slot, so a
  // word is never requested without a guaranteed place to land. It does not
  // look at i_m_ready, which keeps ready out of the rd_en path.
  always_comb begin
    valid_s   = (occ_q != 2'd0);
    pop_s     = valid_s & bus.i_m_ready;
    rd_en_s   = !i_rd_rst && i_enable && !bus.i_fifo_empty &&
                (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
    occ_sum_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  end

  // Next-state for occupancy, pointers, counter and the registered head data.
  always_comb begin
    occ_d      = occ_sum_s[1:0];
    inflight_d = rd_en_s;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    data_d     = data_q;

    if (pop_s) begin
      head_d = ptr_inc(head_q);
      cnt_d  = cnt_q + CNTSIZE'(1);
    end else begin
      head_d = head_q;
      cnt_d  = cnt_q;
    end

    if (inflight_q) begin
      tail_d = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end

    // o_m_data is a register holding the next head word. If nothing older
    // than the captured word survives this cycle, the new head is the word
    // arriving from the FIFO; otherwise it is already in the buffer. With an
    // empty buffer the last value is simply held.
    if (occ_sum_s != 3'd0) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_s)) begin
        data_d = bus.i_fifo_rd_data;
      end else begin
        data_d = mem_q[head_d];
      end
    end else begin
      data_d = data_q;
    end
  end

  // Control state; reset discards buffered and in-flight words.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Buffer storage: the word requested last cycle lands at the tail.
  always_ff @(posedge i_rd_clk) begin
    if (inflight_q) begin
      mem_q[tail_q] <= bus.i_fifo_rd_data;
    end
  end

  assign bus.o_fifo_rd_en = rd_en_s;
  assign bus.o_m_valid    = valid_s;
  assign bus.o_m_data     = data_q;
  assign bus.o_word_cnt   = cnt_q;

  fifo_rd_drain_chk u_chk (
    .clk     (i_rd_clk),
    .rst     (i_rd_rst),
    .occ_sum (occ_sum_s)
  );

endmodule

// -----------------------------------------------------------------------------
// fifo_rd_drain_chk
//   Checks that buffer occupancy plus the arriving word never exceeds the
//   three buffer slots.
//   Ports: clk, rst (active-high), occ_sum (next occupancy before truncation)
// -----------------------------------------------------------------------------
module fifo_rd_drain_chk (
  input logic       clk,
  input logic       rst,
  input logic [2:0] occ_sum
);
  a_occ_max: assert property (@(posedge clk) disable iff (rst) occ_sum <= 3'd3);
endmodule

// File: tb/tb_fifo_rd_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_drain
//   Directed bench for fifo_rd_drain. A small FIFO model (array + pointers,
//   one-cycle registered read data) feeds the main instance; a second
//   instance with a 4-bit counter checks counter wrap.
// -----------------------------------------------------------------------------
module tb_fifo_rd_drain;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic en2;

  always #5 clk = ~clk;

  fifo_rd_drain_if #(.DATASIZE(8), .CNTSIZE(16)) bus1 ();
  fifo_rd_drain_if #(.DATASIZE(8), .CNTSIZE(4))  bus2 ();

  fifo_rd_drain #(.DATASIZE(8), .CNTSIZE(16)) dut (
    .i_rd_clk (clk),
    .i_rd_rst (rst),
    .i_enable (en),
    .bus      (bus1.master)
  );

  fifo_rd_drain #(.DATASIZE(8), .CNTSIZE(4)) dut2 (
    .i_rd_clk (clk),
    .i_rd_rst (rst),
    .i_enable (en2),
    .bus      (bus2.master)
  );

  // FIFO model for the main instance
  logic [7:0] fmem [0:255];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  assign bus1.i_fifo_empty = (wp == rp);

  // Second instance: always non-empty, constant data, always ready
  assign bus2.i_fifo_empty   = 1'b0;
  assign bus2.i_fifo_rd_data = 8'h3C;
  assign bus2.i_m_ready      = 1'b1;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         rd_cnt = 0;
  int         got_idx = 0;
  int         exp_idx = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         rd_base;
  logic [7:0] held;

  // FIFO read port model and downstream capture of accepted words
  always @(posedge clk) begin
    if (bus1.o_fifo_rd_en) begin
      bus1.i_fifo_rd_data <= fmem[rp];
      rp                  <= rp + 8'd1;
      rd_cnt              <= rd_cnt + 1;
    end
    if (!rst && bus1.o_m_valid && bus1.i_m_ready) begin
      got_q.push_back(bus1.o_m_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wp] = d;
    exp_q.push_back(d);
    wp = wp + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
  endtask

  // Compare the next n delivered words with the next n pushed words
  task automatic check_stream(input string tag, input int n);
    chk({tag, "_count"}, got_q.size() - got_idx, n);
    for (int i = 0; i < n; i++) begin
      if (got_idx + i < got_q.size()) begin
        chk($sformatf("%s_w%0d", tag, i), got_q[got_idx + i], exp_q[exp_idx + i]);
      end else begin
        chk($sformatf("%s_w%0d_missing", tag, i), got_q.size(), got_idx + i + 1);
      end
    end
    got_idx += n;
    exp_idx += n;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    en2 = 1'b0;
    bus1.i_m_ready = 1'b1;
    bus1.i_fifo_rd_data = 8'h00;

    // 1. Reset held for two cycles with a non-empty FIFO
    push(8'hA5);
    tick(1);
    chk("rst1_rd_en", bus1.o_fifo_rd_en, 1'b0);
    chk("rst1_valid", bus1.o_m_valid, 1'b0);
    chk("rst1_cnt",   bus1.o_word_cnt, 16'd0);
    chk("rst1_data",  bus1.o_m_data, 8'h00);
    tick(1);
    chk("rst2_rd_en", bus1.o_fifo_rd_en, 1'b0);
    chk("rst2_valid", bus1.o_m_valid, 1'b0);
    chk("rst2_cnt",   bus1.o_word_cnt, 16'd0);

    // 2. Single word: rd_en at N, valid with 0xA5 at N+2
    rst = 1'b0;
    #1;
    chk("single_rd_en_n", bus1.o_fifo_rd_en, 1'b1);
    tick(1);
    chk("single_rd_en_n1", bus1.o_fifo_rd_en, 1'b0);
    chk("single_valid_n1", bus1.o_m_valid, 1'b0);
    tick(1);
    chk("single_valid_n2", bus1.o_m_valid, 1'b1);
    chk("single_data_n2",  bus1.o_m_data, 8'hA5);
    tick(1);
    chk("single_valid_n3", bus1.o_m_valid, 1'b0);
    chk("single_cnt",      bus1.o_word_cnt, 16'd1);
    chk("single_hold",     bus1.o_m_data, 8'hA5);
    check_stream("single", 1);

    // 3. Stream of 16 random words at full throughput
    do_reset();
    rd_base = rd_cnt;
    for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
    #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("stream_rd_en_%0d", i), bus1.o_fifo_rd_en, 1'b1);
      tick(1);
    end
    chk("stream_rd_stop", bus1.o_fifo_rd_en, 1'b0);
    tick(4);
    check_stream("stream", 16);
    chk("stream_cnt",   bus1.o_word_cnt, 16'd16);
    chk("stream_reads", rd_cnt - rd_base, 16);
    chk("stream_idle",  bus1.o_m_valid, 1'b0);

    // 4. Backpressure: ready low for 10 cycles after two words delivered
    do_reset();
    rd_base = rd_cnt;
    for (int i = 0; i < 20; i++) push(8'($urandom_range(0, 255)));
    #1;
    tick(4);
    bus1.i_m_ready = 1'b0;
    held = exp_q[exp_idx + 2];
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_data_%0d", i),  bus1.o_m_data, held);
      chk($sformatf("bp_valid_%0d", i), bus1.o_m_valid, 1'b1);
      if (i >= 1) chk($sformatf("bp_rd_en_%0d", i), bus1.o_fifo_rd_en, 1'b0);
      tick(1);
    end
    chk("bp_reads_held", rd_cnt - rd_base, 5);
    chk("bp_cnt_held",   bus1.o_word_cnt, 16'd2);
    bus1.i_m_ready = 1'b1;
    tick(30);
    check_stream("bp", 20);
    chk("bp_cnt",   bus1.o_word_cnt, 16'd20);
    chk("bp_reads", rd_cnt - rd_base, 20);

    // 5. FIFO empties after 5 words; refill while disabled; enable toggling
    do_reset();
    rd_base = rd_cnt;
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
    #1;
    tick(10);
    chk("empty_reads", rd_cnt - rd_base, 5);
    chk("empty_rd_en", bus1.o_fifo_rd_en, 1'b0);
    chk("empty_valid", bus1.o_m_valid, 1'b0);
    chk("empty_cnt",   bus1.o_word_cnt, 16'd5);
    en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dis_rd_en_%0d", i), bus1.o_fifo_rd_en, 1'b0);
      chk($sformatf("dis_valid_%0d", i), bus1.o_m_valid, 1'b0);
      tick(1);
    end
    en = 1'b1;
    #1;
    chk("en_rd_en", bus1.o_fifo_rd_en, 1'b1);
    tick(2);
    en = 1'b0;
    #1;
    chk("dis2_rd_en",  bus1.o_fifo_rd_en, 1'b0);
    chk("dis2_reads",  rd_cnt - rd_base, 7);
    tick(4);
    chk("dis2_cnt",    bus1.o_word_cnt, 16'd7);
    chk("dis2_valid",  bus1.o_m_valid, 1'b0);
    en = 1'b1;
    tick(20);
    check_stream("en", 11);
    chk("en_cnt",   bus1.o_word_cnt, 16'd11);
    chk("en_reads", rd_cnt - rd_base, 11);

    // 6. Reset with two words buffered and one in flight
    do_reset();
    for (int i = 0; i < 10; i++) push(8'($urandom_range(0, 255)));
    #1;
    tick(4);
    bus1.i_m_ready = 1'b0;
    tick(1);
    chk("midrst_valid_pre", bus1.o_m_valid, 1'b1);
    chk("midrst_cnt_pre",   bus1.o_word_cnt, 16'd2);
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", bus1.o_fifo_rd_en, 1'b0);
    tick(1);
    chk("midrst_valid", bus1.o_m_valid, 1'b0);
    chk("midrst_cnt",   bus1.o_word_cnt, 16'd0);
    check_stream("midrst_pre", 2);
    exp_idx += 3;   // two buffered words and the in-flight one are discarded
    rst = 1'b0;
    bus1.i_m_ready = 1'b1;
    tick(20);
    check_stream("midrst_post", 5);
    chk("midrst_cnt_post", bus1.o_word_cnt, 16'd5);

    // Counter wrap on the 4-bit instance: 17 accepted words -> count 1
    en2 = 1'b1;
    tick(17);
    en2 = 1'b0;
    #1;
    chk("wrap_rd_en", bus2.o_fifo_rd_en, 1'b0);
    tick(5);
    chk("wrap_cnt",   bus2.o_word_cnt, 4'd1);
    chk("wrap_valid", bus2.o_m_valid, 1'b0);
    chk("wrap_data",  bus2.o_m_data, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
